// File: rtl/mips_alu_unit.sv
// Execute-stage ALU: opcode/funct decode to a 4-bit operation, 32-bit result.
// Out is combinational; Out_r is its registered copy for the EX/MEM boundary.
module mips_alu_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUop,
    output logic [31:0] Out,
    output logic [31:0] Out_r
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_INV  = 4'd15;

    localparam logic [5:0] R_TYPE = 6'b000000;

    logic [3:0] r_op;
    logic [4:0] shamt;
    logic signed [31:0] b_s;

    // Variable and fixed shifts share an op: shamt always comes from A.
    always_comb begin
        r_op = OP_INV;
        unique case (funct)
            6'b000000, 6'b000100: r_op = OP_SLL;
            6'b000010, 6'b000110: r_op = OP_SRL;
            6'b000011, 6'b000111: r_op = OP_SRA;
            6'b100000, 6'b100001: r_op = OP_ADD;
            6'b100010, 6'b100011: r_op = OP_SUB;
            6'b100100:            r_op = OP_AND;
            6'b100101:            r_op = OP_OR;
            6'b100110:            r_op = OP_XOR;
            6'b100111:            r_op = OP_NOR;
            6'b101010:            r_op = OP_SLT;
            6'b101011:            r_op = OP_SLTU;
            default:              r_op = OP_INV;
        endcase
    end

    always_comb begin
        ALUop = OP_INV;
        unique case (opcode)
            R_TYPE:               ALUop = r_op;
            6'b100000, 6'b100001,
            6'b100011, 6'b100100,
            6'b100101, 6'b101000,
            6'b101001, 6'b101011,
            6'b001001, 6'b001000: ALUop = OP_ADD;
            6'b001010:            ALUop = OP_SLT;
            6'b001011:            ALUop = OP_SLTU;
            6'b001100:            ALUop = OP_AND;
            6'b001101:            ALUop = OP_OR;
            6'b001110:            ALUop = OP_XOR;
            6'b001111:            ALUop = OP_LUI;
            6'b000100, 6'b000101: ALUop = OP_SUB;
            default:              ALUop = OP_INV;
        endcase
    end

    assign shamt = A[4:0];
    assign b_s   = B;

    always_comb begin
        Out = 32'h0000_0000;
        unique case (ALUop)
            OP_ADD:  Out = A + B;
            OP_SUB:  Out = A - B;
            OP_SLT:  Out = {31'b0, $signed(A) < $signed(B)};
            OP_SLTU: Out = {31'b0, A < B};
            OP_AND:  Out = A & B;
            OP_OR:   Out = A | B;
            OP_XOR:  Out = A ^ B;
            OP_NOR:  Out = ~(A | B);
            OP_SLL:  Out = B << shamt;
            OP_SRL:  Out = B >> shamt;
            OP_SRA:  Out = b_s >>> shamt;
            OP_LUI:  Out = {B[15:0], 16'h0000};
            default: Out = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_r <= 32'h0000_0000;
        end else begin
            Out_r <= Out;
        end
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Randomized bench for mips_alu_unit against an instruction-level model.
// Directed vectors cover the documented corner cases and mid-run reset.
module tb_mips_alu_unit;

    logic        Clock;
    logic        Reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] Out_r;

    int n_vec;
    int n_err;

    mips_alu_unit dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .opcode (opcode),
        .funct  (funct),
        .A      (A),
        .B      (B),
        .ALUop  (ALUop),
        .Out    (Out),
        .Out_r  (Out_r)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: instruction-level semantics, shifts done as arithmetic.
    function automatic longint pow2(input int s);
        return longint'(1) << s;
    endfunction

    function automatic logic [31:0] sll_m(input logic [31:0] b, input int s);
        longint v;
        v = longint'(b) * pow2(s);
        return v[31:0];
    endfunction

    function automatic logic [31:0] srl_m(input logic [31:0] b, input int s);
        longint v;
        v = longint'(b) / pow2(s);
        return v[31:0];
    endfunction

    function automatic logic [31:0] sra_m(input logic [31:0] b, input int s);
        longint v;
        v = longint'(b);
        if (b[31]) v = v - 64'sh1_0000_0000;
        // floor division for negatives
        if (v < 0) v = -((-v + pow2(s) - 1) / pow2(s));
        else v = v / pow2(s);
        return v[31:0];
    endfunction

    function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] eop,
                                  output logic [31:0] eout);
        int s;
        longint sa;
        longint sb;
        s = int'(a[4:0]);
        sa = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        eop = 4'd15;
        eout = 32'h0;
        if (op == 6'd0) begin
            case (fn)
                6'd0, 6'd4:   begin eop = 4'd8;  eout = sll_m(b, s); end
                6'd2, 6'd6:   begin eop = 4'd9;  eout = srl_m(b, s); end
                6'd3, 6'd7:   begin eop = 4'd10; eout = sra_m(b, s); end
                6'd32, 6'd33: begin eop = 4'd0;  eout = a + b; end
                6'd34, 6'd35: begin eop = 4'd1;  eout = a - b; end
                6'd36: begin eop = 4'd4; eout = a & b; end
                6'd37: begin eop = 4'd5; eout = a | b; end
                6'd38: begin eop = 4'd6; eout = a ^ b; end
                6'd39: begin eop = 4'd7; eout = ~(a | b); end
                6'd42: begin eop = 4'd2; eout = (sa < sb) ? 32'd1 : 32'd0; end
                6'd43: begin eop = 4'd3; eout = (a < b) ? 32'd1 : 32'd0; end
                default: begin eop = 4'd15; eout = 32'h0; end
            endcase
        end else begin
            case (op)
                6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43,
                6'd9, 6'd8: begin eop = 4'd0; eout = a + b; end
                6'd10: begin eop = 4'd2; eout = (sa < sb) ? 32'd1 : 32'd0; end
                6'd11: begin eop = 4'd3; eout = (a < b) ? 32'd1 : 32'd0; end
                6'd12: begin eop = 4'd4; eout = a & b; end
                6'd13: begin eop = 4'd5; eout = a | b; end
                6'd14: begin eop = 4'd6; eout = a ^ b; end
                6'd15: begin eop = 4'd11; eout = sll_m(b, 16); end
                6'd4, 6'd5: begin eop = 4'd1; eout = a - b; end
                default: begin eop = 4'd15; eout = 32'h0; end
            endcase
        end
    endfunction

    logic [31:0] last_exp;

    // Drive on the falling edge, check comb outputs, then Out_r after rise.
    task automatic run_vec(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input bit has_lit,
                           input logic [31:0] lit);
        logic [3:0]  eop;
        logic [31:0] eout;
        @(negedge Clock);
        opcode = op;
        funct = fn;
        A = a;
        B = b;
        model(op, fn, a, b, eop, eout);
        #1;
        chk({tag, ".op"}, {28'b0, ALUop}, {28'b0, eop});
        chk({tag, ".out"}, Out, eout);
        if (has_lit) chk({tag, ".lit"}, Out, lit);
        last_exp = eout;
        @(posedge Clock);
        #1;
        chk({tag, ".out_r"}, Out_r, eout);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset_n = 1'b0;
        opcode = 6'd0;
        funct = 6'b100001;
        A = 32'h1234_5678;
        B = 32'h1111_1111;
        last_exp = 32'h0;
        #3;
        chk("rst.out_r", Out_r, 32'h0);
        @(posedge Clock);
        #1;
        chk("rst.hold", Out_r, 32'h0);
        chk("rst.comb", Out, 32'h2345_6789);
        @(negedge Clock);
        Reset_n = 1'b1;

        run_vec("addu", 6'd0, 6'b100001, 32'hB800_B97B, 32'h2000_AECA, 1, 32'hD801_6845);
        run_vec("slt1", 6'd0, 6'b101010, 32'h7, 32'hFFFF_FFFA, 1, 32'h0);
        run_vec("sltu", 6'd0, 6'b101011, 32'h7, 32'hFFFF_FFFA, 1, 32'h1);
        run_vec("slt2", 6'd0, 6'b101010, -32'sd10, -32'sd5, 1, 32'h1);
        run_vec("srl", 6'd0, 6'b000010, 32'h3, 32'h1000_0007, 1, 32'h0200_0000);
        run_vec("sra", 6'd0, 6'b000011, 32'h2, 32'hFFFF_FFFA, 1, 32'hFFFF_FFFE);
        run_vec("subu1", 6'd0, 6'b100011, -32'sd3, -32'sd2, 1, 32'hFFFF_FFFF);
        run_vec("subu2", 6'd0, 6'b100011, 32'h2, -32'sd1, 1, 32'h3);
        run_vec("lw", 6'b100011, 6'd0, 32'h8000_0000, 32'hFFFF_8000, 1, 32'h7FFF_8000);
        run_vec("sw", 6'b101011, 6'd5, 32'h8000_0000, 32'hFFFF_8000, 1, 32'h7FFF_8000);
        run_vec("lui", 6'b001111, 6'($urandom), 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h1234_0000);
        run_vec("undef", 6'd0, 6'b111000, 32'hFFFF_FFFF, 32'h1, 1, 32'h0);
        run_vec("sll0", 6'd0, 6'b000100, 32'hFFFF_FFE0, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F);
        run_vec("sll31", 6'd0, 6'b000000, 32'h1F, 32'h0000_0003, 1, 32'h8000_0000);
        run_vec("nor", 6'd0, 6'b100111, 32'hF0F0_0000, 32'h0000_0F0F, 1, 32'h0F0F_F0F0);
        run_vec("beq", 6'b000100, 6'd0, 32'h5, 32'h5, 1, 32'h0);
        run_vec("badop", 6'b111111, 6'b100000, 32'h5, 32'h5, 1, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            a = $urandom | 32'h8000_0000;
            b = {17'h1FFFF, 15'($urandom)};
            if (i == 250) begin
                Reset_n = 1'b0;
                #1;
                chk("mid_rst.out_r", Out_r, 32'h0);
                chk("mid_rst.out", Out, last_exp);
                @(posedge Clock);
                #1;
                chk("mid_rst.hold", Out_r, 32'h0);
                @(negedge Clock);
                Reset_n = 1'b1;
            end
            run_vec("rand", op, 6'($urandom), a, b, 0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
